// File: rtl/mem_pkg.sv
// Shared definitions for the CPU memory-side access stage.
// No logic; state encoding, RAM geometry and default read latency.
// No flow control of its own.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR      = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam int RAM_DEPTH       = 512;
  localparam int DEF_WAIT_STATES = 1;
  localparam int CNT_W           = 3;

endpackage

// File: rtl/mem_interface_if.sv
// Bundle of control-unit request, RAM port and status signals of mem_interface.
// Pure wiring, zero latency.
// Stalling is signalled back to the control unit through mem_busy.
interface mem_interface_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  Mem_Read;
  logic                  Mem_Write;
  logic                  Mem_enable512x32;
  logic [DATA_WIDTH-1:0] MAR_q;
  logic [DATA_WIDTH-1:0] MDR_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_en;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_data_valid;
  logic                  mem_busy;
  logic                  addr_err;
  logic                  proto_err;

  // Control unit plus RAM environment
  modport master (
    output Mem_Read, Mem_Write, Mem_enable512x32, MAR_q, MDR_q, ram_dout,
    input  ram_addr, ram_din, ram_en, ram_we, mem_data, mem_data_valid,
           mem_busy, addr_err, proto_err
  );

  // The memory access stage
  modport slave (
    input  Mem_Read, Mem_Write, Mem_enable512x32, MAR_q, MDR_q, ram_dout,
    output ram_addr, ram_din, ram_en, ram_we, mem_data, mem_data_valid,
           mem_busy, addr_err, proto_err
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Loadable 3-bit down-counter timing the RAM read latency.
// zero is combinational: high in the cycle whose decrement lands on 0.
// No backpressure; dec is simply ignored once the count is 0.
module mem_wait_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Load takes priority over decrement; the count saturates at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  // The FSM acts on the edge that takes the count to 0
  assign zero = dec && (count == ONE);

endmodule

// File: rtl/mem_interface.sv
// Turns one-cycle control-unit memory strobes into registered 512x32 RAM accesses.
// Read: data at edge k+WAIT_STATES, valid pulse in that cycle; write: one we cycle then DONE.
// mem_busy high outside IDLE stalls the sequencer; strobes while busy are dropped and flagged.
module mem_interface
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input logic            clk,
  input logic            reset,
  mem_interface_if.slave bus
);

  // The wait counter is 3 bits wide, so only 1..7 cycles can be timed
  if ((WAIT_STATES < 1) || (WAIT_STATES > 7)) begin : g_bad_wait_states
    $error("mem_interface: WAIT_STATES must be in 1..7");
  end

  state_t                state;
  logic                  oor_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_din_q;
  logic                  ram_en_q;
  logic                  ram_we_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_data_valid_q;
  logic                  addr_err_q;
  logic                  proto_err_q;

  logic strobe;
  logic rd_req;
  logic wr_req;
  logic oor;
  logic cnt_zero;

  assign strobe = bus.Mem_enable512x32;
  assign rd_req = bus.Mem_Read && !bus.Mem_Write;
  assign wr_req = bus.Mem_Write && !bus.Mem_Read;
  assign oor    = (bus.MAR_q[DATA_WIDTH-1:ADDR_WIDTH] != '0);

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == IDLE) && strobe && rd_req),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (state == RD_WAIT),
    .zero     (cnt_zero)
  );

  // Access sequencer with registered RAM-side and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      oor_q            <= 1'b0;
      ram_addr_q       <= '0;
      ram_din_q        <= '0;
      ram_en_q         <= 1'b0;
      ram_we_q         <= 1'b0;
      mem_data_q       <= '0;
      mem_data_valid_q <= 1'b0;
      addr_err_q       <= 1'b0;
      proto_err_q      <= 1'b0;
    end else begin
      mem_data_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            if (rd_req || wr_req) begin
              ram_addr_q <= bus.MAR_q[ADDR_WIDTH-1:0];
              oor_q      <= oor;
              // An out-of-range access keeps its timing but never touches the RAM
              ram_en_q   <= !oor;
              if (oor) begin
                addr_err_q <= 1'b1;
              end
              if (rd_req) begin
                state <= RD_WAIT;
              end else begin
                state     <= WR;
                ram_din_q <= bus.MDR_q;
                ram_we_q  <= !oor;
              end
            end else begin
              proto_err_q <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (strobe) begin
            proto_err_q <= 1'b1;
          end
          if (cnt_zero) begin
            state            <= DONE;
            ram_en_q         <= 1'b0;
            mem_data_q       <= oor_q ? '0 : bus.ram_dout;
            mem_data_valid_q <= 1'b1;
          end
        end
        WR: begin
          if (strobe) begin
            proto_err_q <= 1'b1;
          end
          state    <= DONE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
        default: begin
          if (strobe) begin
            proto_err_q <= 1'b1;
          end
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_din        = ram_din_q;
  assign bus.ram_en         = ram_en_q;
  assign bus.ram_we         = ram_we_q;
  assign bus.mem_data       = mem_data_q;
  assign bus.mem_data_valid = mem_data_valid_q;
  assign bus.addr_err       = addr_err_q;
  assign bus.proto_err      = proto_err_q;
  assign bus.mem_busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with W=1 (dut1) and W=3 (dut3) instances.
// Read data is checked by a scoreboard queue; timing by counting busy/en/we cycles.
// Each DUT has its own behavioural RAM (synchronous write, combinational read).
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_en;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] mar;
  logic [31:0] mdr;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_interface_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) if1 ();
  mem_interface_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) if3 ();

  mem_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  mem_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3)
  );

  // Shared request lines; the strobe reaches only the selected instance
  assign if1.Mem_Read         = req_rd;
  assign if1.Mem_Write        = req_wr;
  assign if1.MAR_q            = mar;
  assign if1.MDR_q            = mdr;
  assign if1.Mem_enable512x32 = req_en && !sel;
  assign if3.Mem_Read         = req_rd;
  assign if3.Mem_Write        = req_wr;
  assign if3.MAR_q            = mar;
  assign if3.MDR_q            = mdr;
  assign if3.Mem_enable512x32 = req_en && sel;

  // Behavioural RAMs
  logic [31:0] ram1 [512];
  logic [31:0] ram3 [512];
  assign if1.ram_dout = ram1[if1.ram_addr];
  assign if3.ram_dout = ram3[if3.ram_addr];
  always @(posedge clk) if (if1.ram_en && if1.ram_we) ram1[if1.ram_addr] <= if1.ram_din;
  always @(posedge clk) if (if3.ram_en && if3.ram_we) ram3[if3.ram_addr] <= if3.ram_din;

  // Selected-instance view
  logic        o_busy, o_en, o_we, o_valid;
  assign o_busy  = sel ? if3.mem_busy       : if1.mem_busy;
  assign o_en    = sel ? if3.ram_en         : if1.ram_en;
  assign o_we    = sel ? if3.ram_we         : if1.ram_we;
  assign o_valid = sel ? if3.mem_data_valid : if1.mem_data_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected read word
  always @(negedge clk) begin
    if (if1.mem_data_valid || if3.mem_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {30'b0, if3.mem_data_valid, if1.mem_data_valid}, 32'h0);
      end else begin
        check("rd_data", if1.mem_data_valid ? if1.mem_data : if3.mem_data, exp_q.pop_front());
      end
    end
  end

  // One access on the selected instance; counts cycles from the accepting edge
  task automatic access(input logic s, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int busy_n, output int en_n, output int we_n, output int valid_at);
    sel = s; req_rd = rd; req_wr = wr; mar = addr; mdr = data; req_en = 1'b1;
    @(posedge clk);
    #1;
    req_en = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    busy_n = 0; en_n = 0; we_n = 0; valid_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_busy)  busy_n++;
      if (o_en)    en_n++;
      if (o_we)    we_n++;
      if (o_valid) valid_at = i;
      if (!o_busy) break;
    end
  endtask

  int b, e, w, v;

  initial begin
    reset = 1'b0; sel = 1'b0; req_en = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    mar = '0; mdr = '0;
    repeat (2) @(negedge clk);
    check("rst_ram_en",    if1.ram_en,         0);
    check("rst_ram_we",    if1.ram_we,         0);
    check("rst_ram_addr",  if1.ram_addr,       0);
    check("rst_ram_din",   if1.ram_din,        0);
    check("rst_mem_data",  if1.mem_data,       0);
    check("rst_valid",     if1.mem_data_valid, 0);
    check("rst_busy",      if1.mem_busy,       0);
    check("rst_addr_err",  if1.addr_err,       0);
    check("rst_proto_err", if1.proto_err,      0);
    check("rst_busy3",     if3.mem_busy,       0);
    reset = 1'b1;
    @(negedge clk);

    // Write then read, W=1
    access(0, 0, 1, 32'h5, 32'hDEADBEEF, b, e, w, v);
    check("wr_busy_cycles", b, 2);
    check("wr_we_cycles",   w, 1);
    check("wr_en_cycles",   e, 1);
    check("wr_no_valid",    v, 32'hFFFF_FFFF);
    check("wr_ram_word",    ram1[5], 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    access(0, 1, 0, 32'h5, 32'h0, b, e, w, v);
    check("rd1_valid_at",   v, 1);
    check("rd1_busy",       b, 2);
    check("rd1_en_cycles",  e, 1);
    check("rd1_we_cycles",  w, 0);

    // Latency sweep, W=3, top address
    access(1, 0, 1, 32'h1FF, 32'h12345678, b, e, w, v);
    check("wr3_busy",       b, 2);
    exp_q.push_back(32'h12345678);
    access(1, 1, 0, 32'h1FF, 32'h0, b, e, w, v);
    check("rd3_busy",       b, 4);
    check("rd3_valid_at",   v, 3);
    check("rd3_en_cycles",  e, 3);

    // Out-of-range read and write
    exp_q.push_back(32'h0);
    access(1, 1, 0, 32'h200, 32'h0, b, e, w, v);
    check("oor_rd_en",       e, 0);
    check("oor_rd_valid_at", v, 3);
    check("oor_rd_busy",     b, 4);
    check("oor_addr_err",    if3.addr_err, 1);
    exp_q.push_back(32'h12345678);
    access(1, 1, 0, 32'h1FF, 32'h0, b, e, w, v);
    check("good_rd_en",      e, 3);
    check("addr_err_sticky", if3.addr_err, 1);
    access(0, 0, 1, 32'h205, 32'h55, b, e, w, v);
    check("oor_wr_busy",     b, 2);
    check("oor_wr_we",       w, 0);
    check("oor_wr_en",       e, 0);
    check("oor_wr_addr_err", if1.addr_err, 1);
    check("oor_wr_no_write", ram1[5], 32'hDEADBEEF);

    // Both qualifiers set
    access(0, 1, 1, 32'h5, 32'h0, b, e, w, v);
    check("both_busy",      b, 0);
    check("both_en",        e, 0);
    check("both_we",        w, 0);
    check("both_proto_err", if1.proto_err, 1);

    // Second strobe during RD_WAIT
    check("proto3_clear", if3.proto_err, 0);
    exp_q.push_back(32'h12345678);
    sel = 1'b1; req_rd = 1'b1; req_wr = 1'b0; mar = 32'h1FF; req_en = 1'b1;
    @(posedge clk);
    #1;
    req_rd = 1'b0; req_wr = 1'b1; mar = 32'h5; mdr = 32'hBAD;
    @(posedge clk);
    #1;
    req_en = 1'b0; req_wr = 1'b0;
    repeat (6) @(negedge clk);
    check("rdwait_proto_err", if3.proto_err, 1);
    check("rdwait_addr_kept", if3.ram_addr, 32'h1FF);
    check("rdwait_idle",      if3.mem_busy, 0);

    // Reset during RD_WAIT (dut3) and WR (dut1)
    sel = 1'b1; req_rd = 1'b1; mar = 32'h1FF; req_en = 1'b1;
    @(posedge clk);
    #1;
    sel = 1'b0; req_rd = 1'b0; req_wr = 1'b1; mar = 32'h5; mdr = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_en = 1'b0; req_wr = 1'b0;
    #1;
    check("pre_rst_we1", if1.ram_we, 1);
    check("pre_rst_en3", if3.ram_en, 1);
    reset = 1'b0;
    #1;
    check("arst_we1",        if1.ram_we,    0);
    check("arst_en1",        if1.ram_en,    0);
    check("arst_en3",        if3.ram_en,    0);
    check("arst_busy1",      if1.mem_busy,  0);
    check("arst_busy3",      if3.mem_busy,  0);
    check("arst_mem_data3",  if3.mem_data,  0);
    check("arst_addr_err3",  if3.addr_err,  0);
    check("arst_proto_err1", if1.proto_err, 0);
    check("arst_ram_addr3",  if3.ram_addr,  0);
    check("arst_ram_din1",   if1.ram_din,   0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle3", if3.mem_busy, 0);
    check("pending_reads",  exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
